// File: rtl/nes_bus_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | nes_bus_pkg                                                        |
// | Shared CPU-bus constants and types for the bus-master blocks       |
// | (sprite DMA today, DMC sample fetch later).                        |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
package nes_bus_pkg;

  // CPU write to this address starts a sprite transfer
  localparam logic [15:0] DMA_REG_ADDR_C  = 16'h4014;
  // PPU OAM data port, destination of every DMA write
  localparam logic [15:0] OAM_DATA_ADDR_C = 16'h2004;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } dma_state_t;

  typedef logic [15:0] bus_addr_t;

endpackage
`default_nettype wire

// File: rtl/nes_bus_mux.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | nes_bus_mux                                                        |
// | 2:1 bus-master mux: CPU owns the bus unless a DMA engine selects   |
// | itself. Purely combinational.                                      |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module nes_bus_mux (
  input  logic        dma_sel_i,
  input  logic [15:0] cpu_addr_i,
  input  logic        cpu_write_i,
  input  logic [7:0]  cpu_d_i,
  input  logic [15:0] dma_addr_i,
  input  logic        dma_write_i,
  input  logic [7:0]  dma_d_i,
  output logic [15:0] bus_addr_o,
  output logic        bus_write_o,
  output logic [7:0]  bus_d_o
);

  // Select the active bus master's address, strobe and data together
  always_comb begin
    if (dma_sel_i) begin
      bus_addr_o  = dma_addr_i;
      bus_write_o = dma_write_i;
      bus_d_o     = dma_d_i;
    end else begin
      bus_addr_o  = cpu_addr_i;
      bus_write_o = cpu_write_i;
      bus_d_o     = cpu_d_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/oam_dma.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | oam_dma                                                            |
// | Sprite DMA: snoops CPU writes to $4014, halts the core and copies  |
// | XFER_LEN bytes from {page,00} onward to the OAM data port.         |
// | Optional macro OAM_DMA_ALIGN_EN: insert an ALIGN cycle when HALT   |
// | lands on an even cycle so every READ is on an even cycle.          |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module oam_dma
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = DMA_REG_ADDR_C,
  parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_C,
  parameter int          XFER_LEN      = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_write,
  input  logic [7:0]  cpu_d_out,
  output logic        cpu_ready,
  input  logic [7:0]  bus_d_in,
  output logic [15:0] bus_addr,
  output logic        bus_write,
  output logic [7:0]  bus_d_out,
  output logic        dma_active
);

  // Index of the final byte; XFER_LEN is a power of two no larger than 256
  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  dma_state_t state_q, state_d;
  logic [7:0] page_q,  page_d;
  logic [7:0] idx_q,   idx_d;
  logic [7:0] latch_q, latch_d;

  logic       trigger;
  bus_addr_t  dma_addr;
  logic       dma_write;
  logic [7:0] dma_d;

  // Only honoured in IDLE, so a stray hit mid-transfer cannot move the page
  assign trigger = cpu_write && (cpu_addr == DMA_REG_ADDR);

`ifdef OAM_DMA_ALIGN_EN
  logic parity_q;

  // Free-running even/odd cycle marker; even means parity_q == 0
  always_ff @(posedge clk) begin
    if (reset) parity_q <= 1'b0;
    else       parity_q <= ~parity_q;
  end
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (trigger) state_d = HALT;
`ifdef OAM_DMA_ALIGN_EN
      // An odd HALT already puts the following READ on an even cycle
      HALT:  state_d = parity_q ? READ : ALIGN;
      ALIGN: state_d = READ;
`else
      HALT:  state_d = READ;
`endif
      READ:  state_d = WRITE;
      WRITE: state_d = (idx_q == LAST_IDX) ? IDLE : READ;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: bus-master request and the DMA side of the bus mux
  always_comb begin
    dma_active = 1'b1;
    dma_addr   = {page_q, 8'h00};
    dma_write  = 1'b0;
    dma_d      = latch_q;
    case (state_q)
      IDLE:  dma_active = 1'b0;
      READ:  dma_addr   = {page_q, idx_q};
      WRITE: begin
        dma_addr  = OAM_DATA_ADDR;
        dma_write = 1'b1;
      end
      default: ;  // HALT / ALIGN: dummy read of the first source byte
    endcase
  end

  assign cpu_ready = ~dma_active;

  // Datapath next values: page capture, byte index and read-data latch
  always_comb begin
    page_d  = page_q;
    idx_d   = idx_q;
    latch_d = latch_q;
    case (state_q)
      IDLE: if (trigger) begin
        page_d = cpu_d_out;
        idx_d  = 8'h00;
      end
      READ:  latch_d = bus_d_in;
      // Return to zero after the last byte instead of crossing the page
      WRITE: idx_d = (idx_q == LAST_IDX) ? 8'h00 : idx_q + 8'd1;
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      latch_q <= 8'h00;
    end else begin
      page_q  <= page_d;
      idx_q   <= idx_d;
      latch_q <= latch_d;
    end
  end

  nes_bus_mux u_bus_mux (
    .dma_sel_i   (dma_active),
    .cpu_addr_i  (cpu_addr),
    .cpu_write_i (cpu_write),
    .cpu_d_i     (cpu_d_out),
    .dma_addr_i  (dma_addr),
    .dma_write_i (dma_write),
    .dma_d_i     (dma_d),
    .bus_addr_o  (bus_addr),
    .bus_write_o (bus_write),
    .bus_d_o     (bus_d_out)
  );

endmodule
`default_nettype wire

// File: tb/tb_oam_dma.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_oam_dma                                                         |
// | Self-checking bench for oam_dma: randomized transfers compared     |
// | cycle by cycle with a trace built from the transfer rules.         |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic        cpu_write;
  logic [7:0]  cpu_d_out;
  logic        cpu_ready;
  logic [7:0]  bus_d_in;
  logic [15:0] bus_addr;
  logic        bus_write;
  logic [7:0]  bus_d_out;
  logic        dma_active;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [7:0] mem [65536];
  assign bus_d_in = mem[bus_addr];

  // Observed per-cycle trace of one transfer
  logic [15:0] tr_addr [$];
  logic        tr_wr   [$];
  logic [7:0]  tr_data [$];
  logic        tr_act  [$];
  bit          timed_out;
  bit          aborted;
  logic [15:0] trig_addr;
  logic        trig_wr;
  logic [7:0]  trig_d;
  logic        trig_rdy;

  oam_dma dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_write  (cpu_write),
    .cpu_d_out  (cpu_d_out),
    .cpu_ready  (cpu_ready),
    .bus_d_in   (bus_d_in),
    .bus_addr   (bus_addr),
    .bus_write  (bus_write),
    .bus_d_out  (bus_d_out),
    .dma_active (dma_active)
  );

  always #5 clk = ~clk;

  // Cycle index since reset release; cycle 0 is even
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    cpu_write = 1'b0;
    cpu_addr  = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
    cpu_d_out = 8'($urandom);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  function automatic int stall_for(bit halt_odd);
`ifdef OAM_DMA_ALIGN_EN
    return halt_odd ? 513 : 514;
`else
    return 513;
`endif
  endfunction

  // Stimulus only: trigger a transfer whose HALT cycle has the requested
  // parity and record the bus every cycle until cpu_ready returns.
  task automatic run_xfer(input logic [7:0] page, input bit halt_odd,
                          input int inj_at, input int abort_at);
    int wr_seen = 0;
    tr_addr.delete(); tr_wr.delete(); tr_data.delete(); tr_act.delete();
    timed_out = 1'b1;
    aborted   = 1'b0;
    @(posedge clk); #1;
    idle_inputs();
    while (((cyc + 1) % 2) != int'(halt_odd)) begin
      @(posedge clk); #1;
    end
    cpu_addr  = 16'h4014;
    cpu_write = 1'b1;
    cpu_d_out = page;
    @(negedge clk);
    trig_addr = bus_addr; trig_wr = bus_write; trig_d = bus_d_out; trig_rdy = cpu_ready;
    for (int n = 0; n < 700; n++) begin
      @(posedge clk); #1;
      idle_inputs();
      if (n == inj_at) begin
        cpu_addr  = 16'h4014;
        cpu_write = 1'b1;
        cpu_d_out = ~page;
      end
      @(negedge clk);
      if (cpu_ready) begin
        timed_out = 1'b0;
        break;
      end
      tr_addr.push_back(bus_addr);
      tr_wr.push_back(bus_write);
      tr_data.push_back(bus_d_out);
      tr_act.push_back(dma_active);
      if (bus_write) wr_seen++;
      if (abort_at > 0 && wr_seen == abort_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        idle_inputs();
        aborted   = 1'b1;
        timed_out = 1'b0;
        break;
      end
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp++;
    if (cpu_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_ready: got %b want 1", cpu_ready);
    end
    n_cmp++;
    if (dma_active !== 1'b0) begin
      n_bad++; $display("FAIL reset_active: got %b want 0", dma_active);
    end
    n_cmp++;
    if (bus_addr !== cpu_addr || bus_write !== cpu_write || bus_d_out !== cpu_d_out) begin
      n_bad++;
      $display("FAIL reset_mirror: got %h/%b/%h want %h/%b/%h",
               bus_addr, bus_write, bus_d_out, cpu_addr, cpu_write, cpu_d_out);
    end
  endtask

  task automatic test_non_trigger();
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      cpu_d_out = 8'($urandom);
      case ($urandom_range(0, 3))
        0: begin cpu_addr = 16'h4015; cpu_write = 1'b1; end
        1: begin cpu_addr = 16'h4013; cpu_write = 1'b1; end
        2: begin cpu_addr = 16'h4014; cpu_write = 1'b0; end
        default: begin
          cpu_addr  = 16'($urandom);
          if (cpu_addr == 16'h4014) cpu_addr = 16'h4016;
          cpu_write = 1'($urandom);
        end
      endcase
      @(negedge clk);
      n_cmp++;
      if (cpu_ready !== 1'b1 || dma_active !== 1'b0 || bus_addr !== cpu_addr ||
          bus_write !== cpu_write || bus_d_out !== cpu_d_out) begin
        n_bad++;
        $display("FAIL non_trigger[%0d]: got rdy=%b act=%b bus=%h/%b/%h want rdy=1 act=0 bus=%h/%b/%h",
                 n, cpu_ready, dma_active, bus_addr, bus_write, bus_d_out,
                 cpu_addr, cpu_write, cpu_d_out);
      end
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_transfers();
    logic [7:0]  pages [8] = '{8'h02, 8'h02, 8'h03, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00};
    bit          odds  [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    int          injs  [8] = '{-1, -1, -1, 50, -1, -1, -1, -1};
    for (int s = 0; s < 8; s++) begin
      logic [7:0]  page;
      bit          odd;
      int          inj;
      int          exp_stall;
      logic [15:0] e_addr [$];
      logic        e_wr   [$];
      logic [7:0]  e_data [$];
      page = pages[s]; odd = odds[s]; inj = injs[s];
      if (s >= 4) begin
        page = 8'($urandom);
        odd  = 1'($urandom);
        inj  = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 500)) : -1;
      end
      if (s == 0) do_reset();
      for (int i = 0; i < 256; i++)
        mem[{page, 8'(i)}] = (s == 2) ? (8'(i) ^ 8'hA5) : 8'($urandom);
      exp_stall = stall_for(odd);
      e_addr.push_back({page, 8'h00}); e_wr.push_back(1'b0); e_data.push_back(8'h00);
      if (exp_stall == 514) begin
        e_addr.push_back({page, 8'h00}); e_wr.push_back(1'b0); e_data.push_back(8'h00);
      end
      for (int i = 0; i < 256; i++) begin
        e_addr.push_back({page, 8'(i)}); e_wr.push_back(1'b0); e_data.push_back(8'h00);
        e_addr.push_back(16'h2004);      e_wr.push_back(1'b1); e_data.push_back(mem[{page, 8'(i)}]);
      end

      run_xfer(page, odd, inj, 0);

      n_cmp++;
      if (trig_addr !== 16'h4014 || trig_wr !== 1'b1 || trig_d !== page || trig_rdy !== 1'b1) begin
        n_bad++;
        $display("FAIL trigger_pass[%0d]: got %h/%b/%h rdy=%b want 4014/1/%h rdy=1",
                 s, trig_addr, trig_wr, trig_d, trig_rdy, page);
      end
      n_cmp++;
      if (timed_out || tr_addr.size() != exp_stall) begin
        n_bad++;
        $display("FAIL stall_len[%0d]: got %0d cycles (timeout=%b) want %0d",
                 s, tr_addr.size(), timed_out, exp_stall);
      end
      for (int k = 0; k < tr_addr.size() && k < e_addr.size(); k++) begin
        n_cmp++;
        if (tr_addr[k] !== e_addr[k] || tr_wr[k] !== e_wr[k] || tr_act[k] !== 1'b1 ||
            (e_wr[k] && tr_data[k] !== e_data[k])) begin
          n_bad++;
          $display("FAIL trace[%0d][%0d]: got addr=%h wr=%b d=%h act=%b want addr=%h wr=%b d=%h act=1",
                   s, k, tr_addr[k], tr_wr[k], tr_data[k], tr_act[k], e_addr[k], e_wr[k], e_data[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] page, page2;
    bit         odd, odd2;
    int         nw, k0;
    page  = 8'($urandom);
    odd   = 1'($urandom);
    page2 = page ^ 8'h5A;
    odd2  = 1'($urandom);
    for (int i = 0; i < 256; i++) begin
      mem[{page,  8'(i)}] = 8'($urandom);
      mem[{page2, 8'(i)}] = 8'($urandom);
    end
    do_reset();
    run_xfer(page, odd, -1, 100);
    n_cmp++;
    if (!aborted) begin
      n_bad++; $display("FAIL abort_reached: got aborted=%b want 1", aborted);
    end
    nw = 0;
    for (int k = 0; k < tr_wr.size(); k++) begin
      if (tr_wr[k]) begin
        n_cmp++;
        if (tr_data[k] !== mem[{page, 8'(nw)}]) begin
          n_bad++;
          $display("FAIL partial_data[%0d]: got %h want %h", nw, tr_data[k], mem[{page, 8'(nw)}]);
        end
        nw++;
      end
    end
    // run_xfer returned one cycle after the reset edge plus one more; the
    // first sampled cycle after it must already be released
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      n_cmp++;
      if (cpu_ready !== 1'b1 || dma_active !== 1'b0 || bus_write !== cpu_write) begin
        n_bad++;
        $display("FAIL after_reset[%0d]: got rdy=%b act=%b wr=%b want rdy=1 act=0 wr=%b",
                 n, cpu_ready, dma_active, bus_write, cpu_write);
      end
      @(posedge clk); #1;
      idle_inputs();
    end
    run_xfer(page2, odd2, -1, 0);
    k0 = (stall_for(odd2) == 514) ? 2 : 1;
    n_cmp++;
    if (timed_out || tr_addr.size() != stall_for(odd2)) begin
      n_bad++;
      $display("FAIL restart_stall: got %0d want %0d", tr_addr.size(), stall_for(odd2));
    end
    if (tr_addr.size() > k0 + 1) begin
      n_cmp++;
      if (tr_addr[k0] !== {page2, 8'h00} || tr_wr[k0] !== 1'b0) begin
        n_bad++;
        $display("FAIL restart_first_read: got %h/%b want %h/0", tr_addr[k0], tr_wr[k0], {page2, 8'h00});
      end
      n_cmp++;
      if (tr_addr[k0+1] !== 16'h2004 || tr_data[k0+1] !== mem[{page2, 8'h00}]) begin
        n_bad++;
        $display("FAIL restart_first_write: got %h/%h want 2004/%h",
                 tr_addr[k0+1], tr_data[k0+1], mem[{page2, 8'h00}]);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    test_reset();
    test_non_trigger();
    test_transfers();
    test_reset_mid();
    test_non_trigger();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- Sprite-DMA engine on the CPU bus, between the 6502 core and the memory/PPU bus decoder.
- Snoops CPU writes to $4014 and captures the written value as the source page.
- Halts the core through its `ready` input.
- Takes the bus and copies 256 bytes from {page,8'h00}..{page,8'hFF} to the OAM data port $2004, one read/write pair per byte.

Parameters:
- DMA_REG_ADDR, 16'h4014: CPU write address that triggers a transfer.
- OAM_DATA_ADDR, 16'h2004: destination address for every write cycle.
- XFER_LEN, 256: bytes per transfer; must be a power of two, at most 256.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- cpu_addr  in  16  address from CPU core
- cpu_write  in  1  CPU write strobe
- cpu_d_out  in  8  CPU write data
- cpu_ready  out  1  to the CPU `ready` input; 0 halts the core
- bus_d_in  in  8  read data returned by the memory bus for the current bus_addr
- bus_addr  out  16  muxed bus address
- bus_write  out  1  muxed write strobe
- bus_d_out  out  8  muxed write data
- dma_active  out  1  high while the DMA owns the bus

Behaviour:
- Reset values: state IDLE, parity 0, page 0, idx 0, latch 0, cpu_ready 1, dma_active 0.
- Parity bit: toggles every clk, reset to 0. It defines "even" cycles (parity==0).
- Bus mux, combinational:
  - dma_active==0: bus_addr/bus_write/bus_d_out pass cpu_addr/cpu_write/cpu_d_out unchanged.
  - dma_active==1: outputs are driven from the FSM.
- cpu_ready = !dma_active, combinational from state.
- States: IDLE, HALT, ALIGN, READ, WRITE.
- IDLE:
  - At a posedge with cpu_write && cpu_addr==DMA_REG_ADDR: page <= cpu_d_out, idx <= 0, next state HALT.
  - The triggering write itself still reaches the bus.
- HALT, one cycle:
  - dma_active=1; dummy read (bus_addr={page,8'h00}, bus_write=0).
  - Next state READ if parity==1 in HALT, else ALIGN.
- ALIGN, one cycle: same dummy read; next state READ.
- READ:
  - bus_addr={page,idx}, bus_write=0.
  - latch <= bus_d_in at end of cycle.
  - Next state WRITE.
  - READ always falls on an even cycle.
- WRITE:
  - bus_addr=OAM_DATA_ADDR, bus_write=1, bus_d_out=latch.
  - idx <= idx+1.
  - Next state IDLE if idx==XFER_LEN-1, else READ.
- Total stall length: 513 cycles when HALT is on an odd cycle, 514 when HALT is on an even cycle.
- idx is 8 bits and never wraps into the next page. The last source byte is {page,8'hFF}.
- In IDLE, bus_d_out mirrors cpu_d_out.
- Triggers while dma_active are impossible: the CPU is halted. If one is seen anyway, ignore it; page is never overwritten mid-transfer.
- A CPU write to $4014 with d_out=8'h20 selects source $2000-$20FF, no special-casing.
- Reset mid-transfer:
  - Next cycle: state IDLE, cpu_ready=1, dma_active=0, idx=0.
  - No further bus writes; partial OAM contents are left as written.
- bus_write is high only in WRITE, never in HALT, ALIGN or READ.

Optional Feature:
- Macro: OAM_DMA_ALIGN_EN.
- Defined: parity-based ALIGN insertion as above (513/514-cycle stall, matches NES hardware).
- Not defined:
  - ALIGN state and parity register are removed; HALT always goes to READ.
  - Stall is a fixed 513 cycles, regardless of start cycle.

Decomposition:
- Package nes_bus_pkg holds:
  - constants DMA_REG_ADDR_C=16'h4014 and OAM_DATA_ADDR_C=16'h2004;
  - typedef enum logic [2:0] dma_state_t {IDLE, HALT, ALIGN, READ, WRITE};
  - typedef logic [15:0] bus_addr_t.
- One sub-module is natural: nes_bus_mux, a 2:1 mux of {addr,write,d_out} selected by dma_active. It is reused later for the DMC sample fetch.
- FSM, counters and latch stay in oam_dma.

Test Plan:
- Trigger on odd cycle:
  - Stimulus: after reset, hold idle 2 cycles, then CPU writes 8'h02 to $4014 so that HALT lands on an odd cycle.
  - Required: cpu_ready low for exactly 513 cycles.
  - Required: first READ has bus_addr=16'h0200.
  - Required: last WRITE has bus_addr=16'h2004 with data = mem[16'h02FF].
- Trigger on even cycle: as above but shifted one cycle so HALT lands on even parity → cpu_ready low for exactly 514 cycles; ALIGN visible.
- Data integrity:
  - Preload mem[$0300+i]=i^8'hA5, trigger with page 8'h03.
  - Required: 256 writes to $2004 with data sequence 8'hA5,8'hA4,... in order.
  - Required: no bus_write outside WRITE.
- Non-trigger:
  - CPU writes to $4015 and $4013, and reads $4014.
  - Required: cpu_ready stays 1, dma_active stays 0, bus mirrors CPU signals every cycle.
- Reset mid-operation:
  - Assert reset at the 100th WRITE.
  - Required: next cycle cpu_ready=1 and dma_active=0.
  - Required: a fresh trigger afterwards starts at idx 0.
- Macro off:
  - Build without OAM_DMA_ALIGN_EN, trigger on both parities.
  - Required: stall is 513 cycles in both cases.
